qa_shim_c0_read_arbiter: RTL and testbench
==========================================

Name: qa_shim_c0_read_arbiter

Overview:
- Shares the single QLP C0 read-request channel among N_CLIENTS AFU-side requesters.
- Round-robin arbitration; each issued read gets an internal tag written into the mdata field. The client's original mdata is saved and restored on the response.
- C0 read responses are routed back to the requesting client by tag lookup.
- Sits between the AFU clients and the to_qlp side of the shim stack. Read channel only: C0 write/Cg/Ug/Ir responses and all of C1 are handled by other shims and ignored here.

Parameters:
- N_CLIENTS, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 64, tag table depth (power of 2, max 2^14).
- CCI_DATA_WIDTH, 512, response data width.
- CCI_TX_HDR_WIDTH, 61, Tx header width.
- CCI_RX_HDR_WIDTH, 18, Rx header width.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- cli_req_valid  in  N_CLIENTS  per-client read request valid
- cli_req_hdr  in  N_CLIENTS*CCI_TX_HDR_WIDTH  per-client Tx header; client i at slice i
- cli_req_ready  out  N_CLIENTS  one-hot grant; request consumed this cycle
- cli_rsp_valid  out  N_CLIENTS  one-hot response strobe
- cli_rsp_hdr  out  CCI_RX_HDR_WIDTH  response header with client mdata restored (shared by all clients)
- cli_rsp_data  out  CCI_DATA_WIDTH  response data (shared by all clients)
- qlp_C0TxHdr  out  CCI_TX_HDR_WIDTH  header to QLP
- qlp_C0TxRdValid  out  1  read request valid to QLP
- qlp_C0TxAlmFull  in  1  QLP flow control
- qlp_C0RxHdr  in  CCI_RX_HDR_WIDTH  response header from QLP
- qlp_C0RxData  in  CCI_DATA_WIDTH  response data from QLP
- qlp_C0RxRdValid  in  1  read response valid
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  count of busy tags
- err_unknown_tag  out  1  sticky; set on a response with an invalid tag

Behaviour:
- mdata field is bits [13:0] of both Tx and Rx headers.
- Reset (resetb=0, async):
  - all outputs 0; busy vector cleared; RR pointer=0; err_unknown_tag=0.
  - Issued requests are forgotten. Their responses arriving after reset are treated as unknown tags.
- Grant condition, cycle t: any cli_req_valid, qlp_C0TxAlmFull=0, and at least one free tag.
  - Winner = first valid client at or after rr_ptr, wrapping modulo N_CLIENTS.
  - cli_req_ready[winner]=1 (combinational within the cycle).
  - rr_ptr <= winner+1 (wraps); rr_ptr holds when there is no grant.
- Allocation: free tag = lowest-index clear bit of busy.
  - Store {client id, original mdata} in the table entry; set the busy bit.
- Issue at t+1 (registered):
  - qlp_C0TxRdValid=1.
  - qlp_C0TxHdr = client header with [13:0] replaced by zero-extended tag.
  - Otherwise qlp_C0TxRdValid=0 and qlp_C0TxHdr holds its last value.
- AlmFull: no grant in any cycle with qlp_C0TxAlmFull=1. At most one request issues after AlmFull asserts (the registered one), which the AlmFull slack covers.
- Response, qlp_C0RxRdValid=1 at cycle r, tag = RxHdr[13:0]:
  - Valid when tag < MAX_OUTSTANDING and busy[tag]=1.
  - At r+1: cli_rsp_valid[entry.client]=1; cli_rsp_hdr = RxHdr with [13:0]=entry.mdata; cli_rsp_data = RxData.
  - busy[tag] clears at the end of cycle r.
- No response backpressure: clients must always accept cli_rsp_valid.
- Invalid tag: response dropped, err_unknown_tag set (sticky until reset); busy unchanged.
- Simultaneous alloc and free in one cycle: both apply.
  - A tag freed in cycle r is not allocatable until r+1.
  - outstanding = outstanding + alloc − free (net 0 when both occur).
- Table full (all busy): no grants; cli_req_ready all 0 until a response frees a tag.
- Client header bits outside [13:0] pass through unmodified.

Decomposition:
- Package qa_shim_arb_types:
  - MDATA_WIDTH=14 constant.
  - t_client_idx and t_tag typedefs.
  - Packed struct t_tag_entry {t_client_idx client; logic [13:0] mdata}.
  - Functions get_mdata / set_mdata on Tx and Rx headers.
- One sub-module, qa_rr_arbiter: N-way round-robin with enable input, one-hot grant output, internal pointer.
- Tag table: plain register array inside the top module.

Test Plan:
- Reset, then client 0 requests with mdata 0x1234 → qlp_C0TxRdValid at +1 with hdr[13:0]=0. Reply with tag 0 → cli_rsp_valid=4'b0001 at +1, hdr[13:0]=0x1234, data passed through.
- All 4 clients hold valid continuously → grants cycle 0,1,2,3,0,…; issued tags 0,1,2,3,…
- qlp_C0TxAlmFull=1 for 10 cycles while requests are pending → zero grants in those cycles; grants resume the cycle AlmFull drops.
- 64 requests issued with no responses → outstanding=64 and cli_req_ready=0. Return tag 17 → next grant reuses tag 17 one cycle later.
- Response for tag 5 and a new grant in the same cycle, 63 tags busy → new request gets the lowest free tag other than 5; outstanding unchanged.
- Response with tag 40 while not busy → no cli_rsp_valid, err_unknown_tag=1 and stays 1. Reset with 10 requests outstanding → all outputs 0, outstanding=0.

Source files
------------

// File: rtl/qa_shim_arb_types.sv
// Shared types and header helpers for the C0 read arbiter.
// Header helpers assume the default CCI Tx/Rx header widths below.
package qa_shim_arb_types;

   localparam int MDATA_WIDTH      = 14;
   localparam int CLIENT_IDX_WIDTH = 3;
   localparam int TX_HDR_WIDTH     = 61;
   localparam int RX_HDR_WIDTH     = 18;

   typedef logic [CLIENT_IDX_WIDTH-1:0] t_client_idx;
   typedef logic [MDATA_WIDTH-1:0]      t_tag;
   typedef logic [MDATA_WIDTH-1:0]      t_mdata;
   typedef logic [TX_HDR_WIDTH-1:0]     t_tx_hdr;
   typedef logic [RX_HDR_WIDTH-1:0]     t_rx_hdr;

   typedef struct packed {
      t_client_idx client;
      t_mdata      mdata;
   } t_tag_entry;

   function automatic t_mdata get_tx_mdata(input t_tx_hdr hdr);
      return hdr[MDATA_WIDTH-1:0];
   endfunction

   function automatic t_tx_hdr set_tx_mdata(input t_tx_hdr hdr, input t_mdata md);
      t_tx_hdr r;
      r = hdr;
      r[MDATA_WIDTH-1:0] = md;
      return r;
   endfunction

   function automatic t_mdata get_rx_mdata(input t_rx_hdr hdr);
      return hdr[MDATA_WIDTH-1:0];
   endfunction

   function automatic t_rx_hdr set_rx_mdata(input t_rx_hdr hdr, input t_mdata md);
      t_rx_hdr r;
      r = hdr;
      r[MDATA_WIDTH-1:0] = md;
      return r;
   endfunction

endpackage

// File: rtl/qa_rr_arbiter.sv
// N-way round-robin arbiter: grants the first requester at or after the
// pointer, then moves the pointer just past the winner.
module qa_rr_arbiter
   import qa_shim_arb_types::*;
#(
   parameter int N = 4
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        en,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output t_client_idx  grant_idx
);

   t_client_idx ptr_q, ptr_d;
   t_client_idx idx_hi, idx_any, win;
   logic        hit_hi, hit_any;

   always_comb begin
      hit_hi  = 1'b0;
      hit_any = 1'b0;
      idx_hi  = '0;
      idx_any = '0;
      // Descending scan so the lowest matching index is the one left behind.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            hit_any = 1'b1;
            idx_any = t_client_idx'(i);
            if (t_client_idx'(i) >= ptr_q) begin
               hit_hi = 1'b1;
               idx_hi = t_client_idx'(i);
            end
         end
      end
      win = hit_hi ? idx_hi : idx_any;

      grant     = '0;
      grant_idx = win;
      ptr_d     = ptr_q;
      if (en && hit_any) begin
         for (int i = 0; i < N; i++) begin
            grant[i] = (t_client_idx'(i) == win);
         end
         ptr_d = (win == t_client_idx'(N - 1)) ? '0 : win + t_client_idx'(1);
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/qa_shim_c0_read_arbiter.sv
// Shares the QLP C0 read-request channel among N_CLIENTS requesters, tagging
// each read through mdata and routing responses back by tag lookup.
module qa_shim_c0_read_arbiter
   import qa_shim_arb_types::*;
#(
   parameter int N_CLIENTS        = 4,
   parameter int MAX_OUTSTANDING  = 64,
   parameter int CCI_DATA_WIDTH   = 512,
   parameter int CCI_TX_HDR_WIDTH = TX_HDR_WIDTH,
   parameter int CCI_RX_HDR_WIDTH = RX_HDR_WIDTH
) (
   input  logic                                    clk,
   input  logic                                    resetb,
   input  logic [N_CLIENTS-1:0]                    cli_req_valid,
   input  logic [N_CLIENTS*CCI_TX_HDR_WIDTH-1:0]   cli_req_hdr,
   output logic [N_CLIENTS-1:0]                    cli_req_ready,
   output logic [N_CLIENTS-1:0]                    cli_rsp_valid,
   output logic [CCI_RX_HDR_WIDTH-1:0]             cli_rsp_hdr,
   output logic [CCI_DATA_WIDTH-1:0]               cli_rsp_data,
   output logic [CCI_TX_HDR_WIDTH-1:0]             qlp_C0TxHdr,
   output logic                                    qlp_C0TxRdValid,
   input  logic                                    qlp_C0TxAlmFull,
   input  logic [CCI_RX_HDR_WIDTH-1:0]             qlp_C0RxHdr,
   input  logic [CCI_DATA_WIDTH-1:0]               qlp_C0RxData,
   input  logic                                    qlp_C0RxRdValid,
   output logic [$clog2(MAX_OUTSTANDING):0]        outstanding,
   output logic                                    err_unknown_tag
);

   localparam int TAG_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = TAG_W + 1;

   logic [N_CLIENTS-1:0]        grant;
   t_client_idx                 grant_idx;
   logic                        arb_en, alloc, has_free, rsp_hit, tag_in_range;
   logic [TAG_W-1:0]            free_tag, rx_idx;
   t_tag                        rx_tag;
   t_tag_entry                  rx_entry, new_entry;
   logic [CCI_TX_HDR_WIDTH-1:0] cli_hdr [N_CLIENTS];
   logic [CCI_TX_HDR_WIDTH-1:0] sel_hdr;
   t_tag_entry                  tag_tbl [MAX_OUTSTANDING];

   logic [MAX_OUTSTANDING-1:0]  busy_q, busy_d;
   logic                        tx_valid_q, tx_valid_d;
   logic [CCI_TX_HDR_WIDTH-1:0] tx_hdr_q, tx_hdr_d;
   logic [N_CLIENTS-1:0]        rsp_valid_q, rsp_valid_d;
   logic [CCI_RX_HDR_WIDTH-1:0] rsp_hdr_q, rsp_hdr_d;
   logic [CCI_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0]            outstanding_q, outstanding_d;
   logic                        err_q, err_d;

   for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_cli_hdr
      assign cli_hdr[gi] = cli_req_hdr[gi*CCI_TX_HDR_WIDTH +: CCI_TX_HDR_WIDTH];
   end

   always_comb begin
      free_tag = '0;
      has_free = 1'b0;
      for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_tag = TAG_W'(i);
            has_free = 1'b1;
         end
      end
   end

   // Reset gating keeps cli_req_ready low while resetb is held.
   assign arb_en = resetb & ~qlp_C0TxAlmFull & has_free;

   qa_rr_arbiter #(.N(N_CLIENTS)) u_rr (
      .clk       (clk),
      .resetb    (resetb),
      .en        (arb_en),
      .req       (cli_req_valid),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign cli_req_ready = grant;
   assign alloc         = |grant;

   always_comb begin
      sel_hdr = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (grant[i]) sel_hdr = cli_hdr[i];
      end
      new_entry.client = grant_idx;
      new_entry.mdata  = get_tx_mdata(sel_hdr);
   end

   assign rx_tag       = get_rx_mdata(qlp_C0RxHdr);
   assign rx_idx       = rx_tag[TAG_W-1:0];
   assign tag_in_range = int'(rx_tag) < MAX_OUTSTANDING;
   assign rx_entry     = tag_tbl[rx_idx];
   assign rsp_hit      = qlp_C0RxRdValid & tag_in_range & busy_q[rx_idx];

   always_comb begin
      busy_d = busy_q;
      if (rsp_hit) busy_d[rx_idx] = 1'b0;
      // free_tag is never the tag being retired: it came from a clear bit.
      if (alloc)   busy_d[free_tag] = 1'b1;

      tx_valid_d = alloc;
      tx_hdr_d   = alloc ? set_tx_mdata(sel_hdr, MDATA_WIDTH'(free_tag)) : tx_hdr_q;

      for (int i = 0; i < N_CLIENTS; i++) begin
         rsp_valid_d[i] = rsp_hit && (rx_entry.client == t_client_idx'(i));
      end
      rsp_hdr_d  = rsp_hit ? set_rx_mdata(qlp_C0RxHdr, rx_entry.mdata) : rsp_hdr_q;
      rsp_data_d = rsp_hit ? qlp_C0RxData : rsp_data_q;

      outstanding_d = outstanding_q + CNT_W'(alloc) - CNT_W'(rsp_hit);
      err_d         = err_q | (qlp_C0RxRdValid & ~rsp_hit);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         busy_q        <= '0;
         tx_valid_q    <= 1'b0;
         tx_hdr_q      <= '0;
         rsp_valid_q   <= '0;
         rsp_hdr_q     <= '0;
         rsp_data_q    <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         tx_valid_q    <= tx_valid_d;
         tx_hdr_q      <= tx_hdr_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_hdr_q     <= rsp_hdr_d;
         rsp_data_q    <= rsp_data_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

   // Entries are only meaningful while their busy bit is set, so no reset.
   always_ff @(posedge clk) begin
      if (alloc) tag_tbl[free_tag] <= new_entry;
   end

   assign qlp_C0TxRdValid = tx_valid_q;
   assign qlp_C0TxHdr     = tx_hdr_q;
   assign cli_rsp_valid   = rsp_valid_q;
   assign cli_rsp_hdr     = rsp_hdr_q;
   assign cli_rsp_data    = rsp_data_q;
   assign outstanding     = outstanding_q;
   assign err_unknown_tag = err_q;

endmodule

// File: tb/tb_qa_shim_c0_read_arbiter.sv
// Scoreboard bench for qa_shim_c0_read_arbiter: expected issues and responses
// are queued as stimulus is driven and popped as the DUT produces them.
module tb_qa_shim_c0_read_arbiter;

   localparam int N    = 4;
   localparam int MAXO = 64;
   localparam int DW   = 512;
   localparam int TXW  = 61;
   localparam int RXW  = 18;
   localparam int CW   = 7;

   logic            clk = 1'b0;
   logic            resetb = 1'b1;
   logic [N-1:0]    cli_req_valid;
   logic [N*TXW-1:0] cli_req_hdr;
   logic [N-1:0]    cli_req_ready;
   logic [N-1:0]    cli_rsp_valid;
   logic [RXW-1:0]  cli_rsp_hdr;
   logic [DW-1:0]   cli_rsp_data;
   logic [TXW-1:0]  qlp_C0TxHdr;
   logic            qlp_C0TxRdValid;
   logic            qlp_C0TxAlmFull;
   logic [RXW-1:0]  qlp_C0RxHdr;
   logic [DW-1:0]   qlp_C0RxData;
   logic            qlp_C0RxRdValid;
   logic [CW-1:0]   outstanding;
   logic            err_unknown_tag;

   always #5 clk = ~clk;

   qa_shim_c0_read_arbiter dut (
      .clk             (clk),
      .resetb          (resetb),
      .cli_req_valid   (cli_req_valid),
      .cli_req_hdr     (cli_req_hdr),
      .cli_req_ready   (cli_req_ready),
      .cli_rsp_valid   (cli_rsp_valid),
      .cli_rsp_hdr     (cli_rsp_hdr),
      .cli_rsp_data    (cli_rsp_data),
      .qlp_C0TxHdr     (qlp_C0TxHdr),
      .qlp_C0TxRdValid (qlp_C0TxRdValid),
      .qlp_C0TxAlmFull (qlp_C0TxAlmFull),
      .qlp_C0RxHdr     (qlp_C0RxHdr),
      .qlp_C0RxData    (qlp_C0RxData),
      .qlp_C0RxRdValid (qlp_C0RxRdValid),
      .outstanding     (outstanding),
      .err_unknown_tag (err_unknown_tag)
   );

   typedef struct {
      logic [N-1:0]   vld;
      logic [RXW-1:0] hdr;
      logic [DW-1:0]  data;
   } t_rsp_exp;

   logic [TXW-1:0] hdr_arr [N];
   logic [TXW-1:0] tx_q [$];
   t_rsp_exp       rsp_q [$];
   logic [TXW-1:0] exp_tx;
   t_rsp_exp       exp_rsp;

   // Reference model state
   logic [MAXO-1:0] m_busy;
   int              m_ptr;
   int              m_client [MAXO];
   logic [13:0]     m_mdata [MAXO];

   int tests_run = 0;
   int tests_failed = 0;
   logic [N-1:0] r;

   always_comb begin
      cli_req_hdr = '0;
      for (int i = 0; i < N; i++) cli_req_hdr[i*TXW +: TXW] = hdr_arr[i];
   end

   function automatic logic [TXW-1:0] rand_tx();
      logic [63:0] v;
      v = {$urandom, $urandom};
      return v[TXW-1:0];
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Drives one cycle of stimulus, advances the model and queues expectations.
   task automatic drive_cycle(input logic [N-1:0] vld, input logic almf, input logic rv,
                              input int rtag, input int md0, output logic [N-1:0] exp_ready);
      int ftag, win, c;
      logic [TXW-1:0] eh;
      logic [RXW-1:0] rh;
      t_rsp_exp e;
      @(negedge clk);
      for (int i = 0; i < N; i++) hdr_arr[i] = rand_tx();
      if (md0 >= 0) hdr_arr[0][13:0] = 14'(md0);
      rh = RXW'($urandom);
      rh[13:0] = 14'(rtag);
      cli_req_valid   = vld;
      qlp_C0TxAlmFull = almf;
      qlp_C0RxRdValid = rv;
      qlp_C0RxHdr     = rh;
      qlp_C0RxData    = rand_data();

      exp_ready = '0;
      ftag = -1;
      win  = -1;
      for (int t = MAXO - 1; t >= 0; t--) if (!m_busy[t]) ftag = t;
      if (vld != '0 && !almf && ftag >= 0) begin
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (win < 0 && vld[c]) win = c;
         end
         exp_ready[win] = 1'b1;
         eh = hdr_arr[win];
         eh[13:0] = 14'(ftag);
         tx_q.push_back(eh);
         m_client[ftag] = win;
         m_mdata[ftag]  = hdr_arr[win][13:0];
         m_ptr = (win + 1) % N;
      end
      if (rv && rtag < MAXO) begin
         if (m_busy[rtag]) begin
            e.vld  = N'(1) << m_client[rtag];
            e.hdr  = rh;
            e.hdr[13:0] = m_mdata[rtag];
            e.data = qlp_C0RxData;
            rsp_q.push_back(e);
            m_busy[rtag] = 1'b0;
         end
      end
      if (win >= 0) m_busy[ftag] = 1'b1;
      #1;
   endtask

   task automatic idle();
      logic [N-1:0] d;
      drive_cycle('0, 1'b0, 1'b0, 0, -1, d);
   endtask

   task automatic drain();
      logic [N-1:0] d;
      for (int t = MAXO - 1; t >= 0; t--) begin
         if (m_busy[t]) drive_cycle('0, 1'b0, 1'b1, t, -1, d);
      end
      idle();
      idle();
   endtask

   task automatic assert_reset();
      @(negedge clk);
      resetb = 1'b0;
      cli_req_valid   = '0;
      qlp_C0TxAlmFull = 1'b0;
      qlp_C0RxRdValid = 1'b0;
      m_busy = '0;
      m_ptr  = 0;
      tx_q.delete();
      rsp_q.delete();
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      resetb = 1'b1;
   endtask

   // Scoreboard monitor: every registered output event must match the queue head.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (resetb) begin
            if (qlp_C0TxRdValid) begin
               tests_run++;
               if (tx_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL tx_issue: got unexpected issue hdr=%h, required no issue", qlp_C0TxHdr);
               end else begin
                  exp_tx = tx_q.pop_front();
                  if (qlp_C0TxHdr !== exp_tx) begin
                     tests_failed++;
                     $display("FAIL tx_hdr: got %h, required %h", qlp_C0TxHdr, exp_tx);
                  end
               end
            end
            if (cli_rsp_valid !== '0) begin
               tests_run++;
               if (rsp_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL rsp_route: got unexpected rsp valid=%b hdr=%h, required none", cli_rsp_valid, cli_rsp_hdr);
               end else begin
                  exp_rsp = rsp_q.pop_front();
                  if (cli_rsp_valid !== exp_rsp.vld || cli_rsp_hdr !== exp_rsp.hdr || cli_rsp_data !== exp_rsp.data) begin
                     tests_failed++;
                     $display("FAIL rsp_data: got vld=%b hdr=%h data=%h, required vld=%b hdr=%h data=%h",
                              cli_rsp_valid, cli_rsp_hdr, cli_rsp_data, exp_rsp.vld, exp_rsp.hdr, exp_rsp.data);
                  end
               end
            end
         end
      end
   end

   task automatic test_reset();
      assert_reset();
      cli_req_valid = '1;
      #1;
      tests_run++;
      if (cli_req_ready !== '0) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b, required 0", cli_req_ready);
      end
      tests_run++;
      if ({qlp_C0TxRdValid, cli_rsp_valid, err_unknown_tag} !== '0 || outstanding !== '0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got txv=%b rspv=%b err=%b out=%0d, required all 0",
                  qlp_C0TxRdValid, cli_rsp_valid, err_unknown_tag, outstanding);
      end
      tests_run++;
      if (qlp_C0TxHdr !== '0 || cli_rsp_hdr !== '0 || cli_rsp_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_hdr: got txhdr=%h rsphdr=%h, required 0", qlp_C0TxHdr, cli_rsp_hdr);
      end
      cli_req_valid = '0;
      release_reset();
   endtask

   task automatic test_single();
      drive_cycle(4'b0001, 1'b0, 1'b0, 0, 'h1234, r);
      tests_run++;
      if (cli_req_ready !== 4'b0001) begin
         tests_failed++;
         $display("FAIL single_grant: got %b, required 0001", cli_req_ready);
      end
      idle();
      tests_run++;
      if (qlp_C0TxRdValid !== 1'b1 || qlp_C0TxHdr[13:0] !== 14'h0) begin
         tests_failed++;
         $display("FAIL single_issue: got valid=%b tag=%h, required valid=1 tag=0", qlp_C0TxRdValid, qlp_C0TxHdr[13:0]);
      end
      drive_cycle('0, 1'b0, 1'b1, 0, -1, r);
      idle();
      tests_run++;
      if (cli_rsp_valid !== 4'b0001 || cli_rsp_hdr[13:0] !== 14'h1234) begin
         tests_failed++;
         $display("FAIL single_rsp: got vld=%b mdata=%h, required vld=0001 mdata=1234", cli_rsp_valid, cli_rsp_hdr[13:0]);
      end
      idle();
      tests_run++;
      if (tx_q.size() != 0 || rsp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL single_drain: pending tx=%0d rsp=%0d, required 0 0", tx_q.size(), rsp_q.size());
      end
   endtask

   task automatic test_round_robin();
      assert_reset();
      release_reset();
      for (int k = 0; k < 8; k++) begin
         drive_cycle('1, 1'b0, 1'b0, 0, -1, r);
         tests_run++;
         if (cli_req_ready !== (N'(1) << (k % N))) begin
            tests_failed++;
            $display("FAIL rr_grant%0d: got %b, required %b", k, cli_req_ready, N'(1) << (k % N));
         end
      end
      idle();
      drain();
      tests_run++;
      if (tx_q.size() != 0 || rsp_q.size() != 0 || outstanding !== '0) begin
         tests_failed++;
         $display("FAIL rr_drain: pending tx=%0d rsp=%0d out=%0d, required 0 0 0", tx_q.size(), rsp_q.size(), outstanding);
      end
   endtask

   task automatic test_almfull();
      for (int k = 0; k < 3; k++) drive_cycle('1, 1'b0, 1'b0, 0, -1, r);
      for (int k = 0; k < 10; k++) begin
         drive_cycle('1, 1'b1, 1'b0, 0, -1, r);
         tests_run++;
         if (cli_req_ready !== '0) begin
            tests_failed++;
            $display("FAIL almfull_block%0d: got %b, required 0", k, cli_req_ready);
         end
      end
      drive_cycle('1, 1'b0, 1'b0, 0, -1, r);
      tests_run++;
      if (cli_req_ready !== 4'b1000) begin
         tests_failed++;
         $display("FAIL almfull_resume: got %b, required 1000", cli_req_ready);
      end
      idle();
      drain();
      tests_run++;
      if (tx_q.size() != 0 || rsp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL almfull_drain: pending tx=%0d rsp=%0d, required 0 0", tx_q.size(), rsp_q.size());
      end
   endtask

   task automatic test_table_full();
      assert_reset();
      release_reset();
      for (int k = 0; k < MAXO; k++) begin
         drive_cycle('1, 1'b0, 1'b0, 0, -1, r);
         tests_run++;
         if (cli_req_ready !== r) begin
            tests_failed++;
            $display("FAIL fill_grant%0d: got %b, required %b", k, cli_req_ready, r);
         end
      end
      drive_cycle('1, 1'b0, 1'b0, 0, -1, r);
      tests_run++;
      if (cli_req_ready !== '0 || outstanding !== CW'(64)) begin
         tests_failed++;
         $display("FAIL full_stall: got ready=%b out=%0d, required ready=0 out=64", cli_req_ready, outstanding);
      end
      drive_cycle('1, 1'b0, 1'b1, 17, -1, r);
      tests_run++;
      if (cli_req_ready !== '0) begin
         tests_failed++;
         $display("FAIL full_free_same_cycle: got %b, required 0", cli_req_ready);
      end
      drive_cycle('1, 1'b0, 1'b0, 0, -1, r);
      tests_run++;
      if (cli_req_ready !== r || r === '0) begin
         tests_failed++;
         $display("FAIL full_regrant: got %b, required %b", cli_req_ready, r);
      end
      idle();
      tests_run++;
      if (qlp_C0TxRdValid !== 1'b1 || qlp_C0TxHdr[13:0] !== 14'd17) begin
         tests_failed++;
         $display("FAIL full_reuse17: got valid=%b tag=%0d, required valid=1 tag=17", qlp_C0TxRdValid, qlp_C0TxHdr[13:0]);
      end
   endtask

   task automatic test_simul_alloc_free();
      drive_cycle('0, 1'b0, 1'b1, 30, -1, r);
      drive_cycle('1, 1'b0, 1'b1, 5, -1, r);
      tests_run++;
      if (cli_req_ready !== r || r === '0) begin
         tests_failed++;
         $display("FAIL simul_grant: got %b, required %b", cli_req_ready, r);
      end
      idle();
      tests_run++;
      if (qlp_C0TxHdr[13:0] !== 14'd30 || outstanding !== CW'(63)) begin
         tests_failed++;
         $display("FAIL simul_tag: got tag=%0d out=%0d, required tag=30 out=63", qlp_C0TxHdr[13:0], outstanding);
      end
      drive_cycle('1, 1'b0, 1'b0, 0, -1, r);
      idle();
      tests_run++;
      if (qlp_C0TxHdr[13:0] !== 14'd5 || outstanding !== CW'(64)) begin
         tests_failed++;
         $display("FAIL simul_next: got tag=%0d out=%0d, required tag=5 out=64", qlp_C0TxHdr[13:0], outstanding);
      end
      drain();
      tests_run++;
      if (tx_q.size() != 0 || rsp_q.size() != 0 || outstanding !== '0) begin
         tests_failed++;
         $display("FAIL simul_drain: pending tx=%0d rsp=%0d out=%0d, required 0 0 0", tx_q.size(), rsp_q.size(), outstanding);
      end
   endtask

   task automatic test_unknown_tag();
      assert_reset();
      release_reset();
      for (int k = 0; k < 10; k++) drive_cycle(4'b0101, 1'b0, 1'b0, 0, -1, r);
      idle();
      drive_cycle('0, 1'b0, 1'b1, 40, -1, r);
      idle();
      tests_run++;
      if (err_unknown_tag !== 1'b1 || outstanding !== CW'(10)) begin
         tests_failed++;
         $display("FAIL unknown_tag40: got err=%b out=%0d, required err=1 out=10", err_unknown_tag, outstanding);
      end
      drive_cycle('0, 1'b0, 1'b1, 100, -1, r);
      idle();
      idle();
      idle();
      tests_run++;
      if (err_unknown_tag !== 1'b1 || outstanding !== CW'(10)) begin
         tests_failed++;
         $display("FAIL unknown_sticky: got err=%b out=%0d, required err=1 out=10", err_unknown_tag, outstanding);
      end
      assert_reset();
      tests_run++;
      if (err_unknown_tag !== 1'b0 || outstanding !== '0 || qlp_C0TxRdValid !== 1'b0 ||
          cli_rsp_valid !== '0 || qlp_C0TxHdr !== '0 || cli_rsp_hdr !== '0) begin
         tests_failed++;
         $display("FAIL reset_outstanding: got err=%b out=%0d txv=%b rspv=%b, required all 0",
                  err_unknown_tag, outstanding, qlp_C0TxRdValid, cli_rsp_valid);
      end
      release_reset();
      drive_cycle('0, 1'b0, 1'b1, 3, -1, r);
      idle();
      tests_run++;
      if (err_unknown_tag !== 1'b1 || cli_rsp_valid !== '0) begin
         tests_failed++;
         $display("FAIL stale_tag: got err=%b rspv=%b, required err=1 rspv=0", err_unknown_tag, cli_rsp_valid);
      end
      idle();
      tests_run++;
      if (tx_q.size() != 0 || rsp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL unknown_drain: pending tx=%0d rsp=%0d, required 0 0", tx_q.size(), rsp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      cli_req_valid   = '0;
      qlp_C0TxAlmFull = 1'b0;
      qlp_C0RxRdValid = 1'b0;
      qlp_C0RxHdr     = '0;
      qlp_C0RxData    = '0;
      for (int i = 0; i < N; i++) hdr_arr[i] = '0;
      m_busy = '0;
      m_ptr  = 0;
      #1 resetb = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_almfull();
      test_table_full();
      test_simul_alloc_free();
      test_unknown_tag();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
